// File: rtl/xc_malu_divrem_seq.sv
// Sequential restoring divider for div/divu/rem/remu with RISC-V semantics.
// One quotient bit per cycle; optional single-cycle completion for x/0 and signed overflow.
module xc_malu_divrem_seq #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        flush,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_rem,
    input  logic        op_remu,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        ack,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_ready;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_div;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_is_rem;

    logic              w_any_op;
    logic              w_signed;
    logic              w_is_rem;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_early;
    logic [XLEN-1:0]   w_early_res;
    logic              w_accept;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_fin;
    logic [XLEN-1:0]   w_rem_fin;
    logic [XLEN-1:0]   w_res_fin;

    // Operation decode with div > divu > rem > remu priority
    always_comb begin
        w_any_op   = op_div | op_divu | op_rem | op_remu;
        w_signed   = op_div | (!op_divu & op_rem);
        w_is_rem   = !op_div & !op_divu;
        w_neg1     = w_signed & rs1[XLEN-1];
        w_neg2     = w_signed & rs2[XLEN-1];
        w_abs1     = w_neg1 ? (XLEN'(0) - rs1) : rs1;
        w_abs2     = w_neg2 ? (XLEN'(0) - rs2) : rs2;
        w_div_zero = (rs2 == XLEN'(0));
        w_ovf      = w_signed & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
        w_early    = EARLY_OUT & (w_div_zero | w_ovf);
        if (w_is_rem) begin
            w_early_res = w_div_zero ? rs1 : XLEN'(0);
        end else begin
            w_early_res = w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
        w_accept = valid & w_any_op &
                   ((r_state == S_IDLE) | ((r_state == S_DONE) & ack));
    end

    // One restoring step plus the sign fix-up applied on the final step
    always_comb begin
        w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_div};
        if (!w_trial[XLEN]) begin
            w_rem_nxt = w_trial[XLEN-1:0];
            w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
        end else begin
            w_rem_nxt = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
            w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
        end
        w_quo_fin = r_sign_q ? (XLEN'(0) - w_quo_nxt) : w_quo_nxt;
        w_rem_fin = r_sign_r ? (XLEN'(0) - w_rem_nxt) : w_rem_nxt;
        w_res_fin = r_is_rem ? w_rem_fin : w_quo_fin;
    end

    // Control FSM and datapath registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_count  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else if (w_accept) begin
            r_quo    <= w_abs1;
            r_div    <= w_abs2;
            r_rem    <= '0;
            r_count  <= '0;
            // a zero divisor yields all-ones quotient regardless of operand signs
            r_sign_q <= w_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]) & !w_div_zero;
            r_sign_r <= w_neg1;
            r_is_rem <= w_is_rem;
            r_busy   <= 1'b1;
            if (w_early) begin
                r_state  <= S_DONE;
                r_ready  <= 1'b1;
                r_result <= w_early_res;
            end else begin
                r_state <= S_CALC;
                r_ready <= 1'b0;
            end
        end else begin
            case (r_state)
                S_CALC: begin
                    r_quo   <= w_quo_nxt;
                    r_rem   <= w_rem_nxt;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(XLEN - 1)) begin
                        r_state  <= S_DONE;
                        r_ready  <= 1'b1;
                        r_result <= w_res_fin;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign ready  = r_ready;
    assign result = r_result;

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Directed bench for xc_malu_divrem_seq: scoreboard of expected results against
// both the early-out and the full-iteration configurations.
module tb_xc_malu_divrem_seq;

    logic        g_clk;
    logic        g_resetn;
    logic        valid, valid_b;
    logic        flush;
    logic        op_div, op_divu, op_rem, op_remu;
    logic [31:0] rs1, rs2;
    logic        ack, ack_b;
    logic        busy, ready;
    logic [31:0] result;
    logic        busy_b, ready_b;
    logic [31:0] result_b;

    int          n_cmp;
    int          n_err;
    logic [31:0] sb[$];
    logic [31:0] last_res;

    xc_malu_divrem_seq #(.EARLY_OUT(1'b1)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .flush(flush),
        .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
        .rs1(rs1), .rs2(rs2), .ack(ack),
        .busy(busy), .ready(ready), .result(result)
    );

    xc_malu_divrem_seq #(.EARLY_OUT(1'b0)) u_dut_full (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_b), .flush(flush),
        .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
        .rs1(rs1), .rs2(rs2), .ack(ack_b),
        .busy(busy_b), .ready(ready_b), .result(result_b)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 0=div 1=divu 2=rem 3=remu
    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            0:       model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            1:       model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2:       model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input int op, input logic [31:0] a, input logic [31:0] b);
        is_special = (b == 0) ||
                     (((op == 0) || (op == 2)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    task automatic set_op(input int op);
        op_div  = (op == 0);
        op_divu = (op == 1);
        op_rem  = (op == 2);
        op_remu = (op == 3);
    endtask

    task automatic clr_req();
        valid = 1'b0; valid_b = 1'b0;
        op_div = 1'b0; op_divu = 1'b0; op_rem = 1'b0; op_remu = 1'b0;
        rs1 = $urandom; rs2 = $urandom;
    endtask

    // Wait (bounded) for ready after the accept edge, then score the result
    task automatic wait_score(input string tag, input bit use_b, input bit early);
        int lat;
        logic [31:0] exp;
        lat = 0;
        while (!(use_b ? ready_b : ready) && lat < 40) begin
            @(posedge g_clk); #1;
            lat++;
        end
        if (early) check({tag, "_lat"}, 32'(lat <= 1), 32'd1);
        else       check({tag, "_lat"}, 32'(lat), 32'd32);
        check({tag, "_busy"}, 32'(use_b ? busy_b : busy), 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_res"}, use_b ? result_b : result, exp);
            last_res = exp;
        end else begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input bit use_b);
        @(negedge g_clk);
        if (use_b) valid_b = 1'b1; else valid = 1'b1;
        set_op(op); rs1 = a; rs2 = b;
        sb.push_back(model(op, a, b));
        @(posedge g_clk); #1;
        clr_req();
    endtask

    // Hold in DONE for 'hold' cycles with stray requests, then acknowledge
    task automatic retire(input string tag, input bit use_b, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge g_clk);
            if (use_b) valid_b = 1'b1; else valid = 1'b1;
            set_op(1); rs1 = $urandom; rs2 = 32'd3;
            @(posedge g_clk); #1;
            check({tag, "_hold_rdy"}, 32'(use_b ? ready_b : ready), 32'd1);
            check({tag, "_hold_res"}, use_b ? result_b : result, last_res);
        end
        @(negedge g_clk);
        clr_req();
        if (use_b) ack_b = 1'b1; else ack = 1'b1;
        @(posedge g_clk); #1;
        ack = 1'b0; ack_b = 1'b0;
        check({tag, "_ack_rdy"}, 32'(use_b ? ready_b : ready), 32'd0);
        check({tag, "_ack_busy"}, 32'(use_b ? busy_b : busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b, input bit use_b);
        issue(op, a, b, use_b);
        wait_score(tag, use_b, is_special(op, a, b) && !use_b);
        retire(tag, use_b, 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; last_res = '0;
        g_resetn = 1'b0; flush = 1'b0; ack = 1'b0; ack_b = 1'b0;
        clr_req();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_result_full", result_b, 32'd0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;

        run_op("divu_100_7", 1, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", 3, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_m7_2", 2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_7_m2", 2, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_by0", 1, 32'h1234, 32'd0, 1'b0);
        run_op("remu_by0", 3, 32'h1234, 32'd0, 1'b0);
        run_op("div_by0_neg", 0, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("divu_by0_full", 1, 32'h1234, 32'd0, 1'b1);
        run_op("remu_by0_full", 3, 32'h1234, 32'd0, 1'b1);
        run_op("div_by0_neg_full", 0, 32'hFFFF_FF00, 32'd0, 1'b1);
        run_op("div_ovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf_full", 0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_min_1", 1, 32'h8000_0000, 32'd1, 1'b0);

        // Flush on the 10th CALC cycle
        @(negedge g_clk);
        valid = 1'b1; set_op(1); rs1 = 32'd1000; rs2 = 32'd9;
        @(posedge g_clk); #1;
        clr_req();
        repeat (9) @(posedge g_clk);
        @(negedge g_clk);
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        valid = 1'b1; set_op(0); rs1 = 32'd50; rs2 = 32'd5;
        @(posedge g_clk); #1;
        flush = 1'b0;
        clr_req();
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(ready), 32'd0);
        check("flush_result", result, last_res);
        run_op("divu_9_3", 1, 32'd9, 32'd3, 1'b0);

        // Back-to-back accept in DONE, then a held result
        issue(1, 32'd100, 32'd7, 1'b0);
        wait_score("b2b_first", 1'b0, 1'b0);
        @(negedge g_clk);
        ack = 1'b1; valid = 1'b1; set_op(3); rs1 = 32'd10; rs2 = 32'd4;
        sb.push_back(model(3, 32'd10, 32'd4));
        @(posedge g_clk); #1;
        ack = 1'b0;
        clr_req();
        check("b2b_ready_low", 32'(ready), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_score("b2b_second", 1'b0, 1'b0);
        retire("b2b_second", 1'b0, 5);

        // A few random operations
        for (int i = 0; i < 6; i++) begin
            run_op("rand", i % 4, $urandom, 32'($urandom_range(1, 32'hFFFF)), 1'b0);
        end

        // Asynchronous reset mid-CALC
        issue(0, 32'd12345, 32'd17, 1'b0);
        void'(sb.pop_back());
        repeat (5) @(posedge g_clk);
        #3;
        g_resetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        run_op("post_rst_div", 0, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
